// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-unit opcodes, LSU state/size types and the memory-op size decoder
package cpu_pkg;
  typedef enum logic [5:0] {
    CU_NOP = 6'h00, CU_ADD = 6'h01, CU_SUB = 6'h02,
    CU_LB  = 6'h10, CU_LH  = 6'h11, CU_LW  = 6'h12, CU_LBU = 6'h13, CU_LHU = 6'h14,
    CU_SB  = 6'h18, CU_SH  = 6'h19, CU_SW  = 6'h1A
  } cu_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;
  typedef struct packed {
    logic      mem;
    logic      load;
    logic      sgn;
    lsu_size_t size;
  } lsu_dec_t;
  function automatic lsu_dec_t lsu_decode(input logic [5:0] op);
    lsu_dec_t d;
    case (op)
      CU_LB:   d = '{1'b1, 1'b1, 1'b1, SZ_B};
      CU_LH:   d = '{1'b1, 1'b1, 1'b1, SZ_H};
      CU_LW:   d = '{1'b1, 1'b1, 1'b1, SZ_W};
      CU_LBU:  d = '{1'b1, 1'b1, 1'b0, SZ_B};
      CU_LHU:  d = '{1'b1, 1'b1, 1'b0, SZ_H};
      CU_SB:   d = '{1'b1, 1'b0, 1'b0, SZ_B};
      CU_SH:   d = '{1'b1, 1'b0, 1'b0, SZ_H};
      CU_SW:   d = '{1'b1, 1'b0, 1'b0, SZ_W};
      default: d = '{1'b0, 1'b0, 1'b0, SZ_W};
    endcase
    return d;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store-data replication and load-data lane shift for the LSU
module lsu_lane_align
  import cpu_pkg::*;
(
  input  lsu_size_t   sz,
  input  logic [1:0]  addr,
  input  logic [31:0] sd,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  assign be    = sz == SZ_B ? 4'b0001 << addr : sz == SZ_H ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign wdata = sz == SZ_B ? {4{sd[7:0]}} : sz == SZ_H ? {2{sd[15:0]}} : sd;
  assign rdata = sz == SZ_B ? rd >> {addr, 3'b000} : sz == SZ_H ? rd >> {addr[1], 4'b0000} : rd;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: req/ack data-memory stage with core stall; LSU_MISALIGN_TRAP_EN enables misalign trapping
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              memStart,
  input  logic [5:0]        cuOP,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [DATA_W-1:0] storeData,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWData,
  output logic [3:0]        busByteEn,
  output logic              busRen,
  output logic              busWen,
  input  logic              busAck,
  input  logic [DATA_W-1:0] busRData,
  output logic [DATA_W-1:0] memload,
  output logic              memValid,
  output logic              stall,
  output logic              misalign
);
  lsu_state_t  state;
  lsu_size_t   size_q, size_sel;
  lsu_dec_t    dec;
  logic [1:0]  a_q, a_sel;
  logic [3:0]  be;
  logic [31:0] wd, rd_al;
  logic        start, mis, mis_q, unused_sgn;
  assign dec        = lsu_decode(cuOP);
  assign unused_sgn = dec.sgn;
  assign start      = state == IDLE && memStart && dec.mem;
  assign stall      = start || state == BUSY;
  assign misalign   = mis_q;
  // Aligner sees live inputs when launching and the captured lane/size while waiting for read data
  assign size_sel   = state == IDLE ? dec.size : size_q;
  assign a_sel      = state == IDLE ? aluOut[1:0] : a_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (dec.size == SZ_H && aluOut[0]) || (dec.size == SZ_W && |aluOut[1:0]);
`else
  assign mis = 1'b0;
`endif
  lsu_lane_align u_align (
    .sz(size_sel), .addr(a_sel), .sd(storeData), .rd(busRData),
    .be(be), .wdata(wd), .rdata(rd_al)
  );
  always_ff @(posedge clk)
    if (nRST) begin
      state     <= IDLE;
      size_q    <= SZ_B;
      a_q       <= 2'b00;
      busAddr   <= '0;
      busWData  <= '0;
      busByteEn <= 4'b0000;
      busRen    <= 1'b0;
      busWen    <= 1'b0;
      memload   <= '0;
      memValid  <= 1'b0;
      mis_q     <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            size_q <= dec.size;
            a_q    <= aluOut[1:0];
            if (mis) begin
              state    <= DONE;
              memValid <= 1'b1;
              mis_q    <= 1'b1;
              memload  <= '0;
            end else begin
              state     <= BUSY;
              busAddr   <= {aluOut[ADDR_W-1:2], 2'b00};
              busWData  <= wd;
              busByteEn <= be;
              busRen    <= dec.load;
              busWen    <= !dec.load;
            end
          end
        BUSY:
          if (busAck) begin
            state    <= DONE;
            memValid <= 1'b1;
            busRen   <= 1'b0;
            busWen   <= 1'b0;
            if (busRen) memload <= rd_al;
          end
        default: begin
          state    <= IDLE;
          memValid <= 1'b0;
          mis_q    <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven vectors with a completion scoreboard plus hand-written corner sequences
module tb_load_store_unit;
  import cpu_pkg::*;
  logic        tb_clk = 1'b0;
  logic        nRST, memStart, busAck;
  logic [5:0]  cuOP;
  logic [31:0] aluOut, storeData, busRData;
  logic [31:0] busAddr, busWData, memload;
  logic [3:0]  busByteEn;
  logic        busRen, busWen, memValid, stall, misalign;
  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr, sd, rd;
    int          nw;
    logic [31:0] ba;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ld;
    logic [31:0] ml;
  } vec_t;
  typedef struct {
    logic [31:0] ml;
    logic        mis;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[9];
  int   n_vec = 0, n_bad = 0;
  always #5 tb_clk = ~tb_clk;
  load_store_unit dut (
    .clk(tb_clk), .nRST(nRST), .memStart(memStart), .cuOP(cuOP), .aluOut(aluOut),
    .storeData(storeData), .busAddr(busAddr), .busWData(busWData), .busByteEn(busByteEn),
    .busRen(busRen), .busWen(busWen), .busAck(busAck), .busRData(busRData),
    .memload(memload), .memValid(memValid), .stall(stall), .misalign(misalign)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge tb_clk)
    if (memValid) begin
      if (sb.size() == 0) chk("memValid_unexpected", memValid, 0);
      else begin
        e = sb.pop_front();
        chk("memload", memload, e.ml);
        chk("misalign", misalign, e.mis);
      end
    end
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask
  task automatic run(input vec_t v);
    memStart = 1'b1; cuOP = v.op; aluOut = v.addr; storeData = v.sd;
    sb.push_back('{v.ml, 1'b0});
    @(negedge tb_clk);
    chk("stall_start", stall, 1);
    step();
    memStart = 1'b0;
    storeData = 32'hDEADDEAD;
    for (int i = 0; i <= v.nw; i++) begin
      if (i == v.nw) begin busAck = 1'b1; busRData = v.rd; end
      else busRData = 32'h5A5A5A5A;
      @(negedge tb_clk);
      chk("busAddr", busAddr, v.ba);
      chk("busByteEn", busByteEn, v.be);
      chk("busWData", busWData, v.wd);
      chk("busRen", busRen, v.ld);
      chk("busWen", busWen, !v.ld);
      chk("stall_busy", stall, 1);
      chk("memValid_busy", memValid, 0);
      step();
    end
    busAck = 1'b0;
    @(negedge tb_clk);
    chk("stall_done", stall, 0);
    chk("memValid_done", memValid, 1);
    chk("busRen_done", busRen, 0);
    chk("busWen_done", busWen, 0);
    step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    tbl[0] = '{CU_LB,  32'h1003, 32'h0,        32'hAABBCCDD, 0, 32'h1000, 4'b1000, 32'h0,        1'b1, 32'h000000AA};
    tbl[1] = '{CU_SH,  32'h2002, 32'h12345678, 32'h0,        3, 32'h2000, 4'b1100, 32'h56785678, 1'b0, 32'h000000AA};
    tbl[2] = '{CU_LW,  32'h3000, 32'h0,        32'h11223344, 1, 32'h3000, 4'b1111, 32'h0,        1'b1, 32'h11223344};
    tbl[3] = '{CU_LHU, 32'h0006, 32'h0,        32'hAABBCCDD, 0, 32'h0004, 4'b1100, 32'h0,        1'b1, 32'h0000AABB};
    tbl[4] = '{CU_LH,  32'h0004, 32'h0,        32'h8899AABB, 2, 32'h0004, 4'b0011, 32'h0,        1'b1, 32'h8899AABB};
    tbl[5] = '{CU_LBU, 32'h0005, 32'h0,        32'h01020304, 0, 32'h0004, 4'b0010, 32'h0,        1'b1, 32'h00010203};
    tbl[6] = '{CU_SB,  32'h0101, 32'h000000EF, 32'h0,        1, 32'h0100, 4'b0010, 32'hEFEFEFEF, 1'b0, 32'h00010203};
    tbl[7] = '{CU_SW,  32'h0200, 32'hDEADBEEF, 32'h0,        0, 32'h0200, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h00010203};
    tbl[8] = '{CU_LB,  32'h0000, 32'h0,        32'h000000FF, 0, 32'h0000, 4'b0001, 32'h0,        1'b1, 32'h000000FF};
    nRST = 1'b1; memStart = 1'b0; cuOP = CU_NOP; aluOut = 0; storeData = 0; busAck = 1'b1; busRData = 32'hFFFFFFFF;
    step();
    step();
    @(negedge tb_clk);
    chk("rst_busAddr", busAddr, 0);
    chk("rst_busWData", busWData, 0);
    chk("rst_busByteEn", busByteEn, 0);
    chk("rst_busRen", busRen, 0);
    chk("rst_busWen", busWen, 0);
    chk("rst_memload", memload, 0);
    chk("rst_memValid", memValid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_misalign", misalign, 0);
    step();
    nRST = 1'b0;
    step();
    busAck = 1'b0;
    @(negedge tb_clk);
    chk("idle_ack_memValid", memValid, 0);
    chk("idle_ack_memload", memload, 0);
    step();
    for (int i = 0; i < 9; i++) run(tbl[i]);
    memStart = 1'b1; cuOP = CU_ADD; aluOut = 32'h1000;
    @(negedge tb_clk);
    chk("nonmem_stall", stall, 0);
    step();
    memStart = 1'b0;
    @(negedge tb_clk);
    chk("nonmem_busRen", busRen, 0);
    chk("nonmem_busWen", busWen, 0);
    chk("nonmem_memValid", memValid, 0);
    step();
    memStart = 1'b1; cuOP = CU_LW; aluOut = 32'h3000;
    sb.push_back('{32'hCAFEF00D, 1'b0});
    step();
    aluOut = 32'h5000;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin busAck = 1'b1; busRData = 32'hCAFEF00D; end
      @(negedge tb_clk);
      cnt += int'(busRen);
      chk("b2b_busAddr", busAddr, 32'h3000);
      step();
    end
    busAck = 1'b0;
    @(negedge tb_clk);
    chk("b2b_memValid", memValid, 1);
    chk("b2b_stall_done", stall, 0);
    step();
    memStart = 1'b0;
    @(negedge tb_clk);
    chk("b2b_busRen_after", busRen, 0);
    chk("b2b_stall_after", stall, 0);
    chk("b2b_ren_cycles", cnt, 3);
    step();
    memStart = 1'b1; cuOP = CU_LW; aluOut = 32'h3000;
    step();
    memStart = 1'b0;
    step();
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    @(negedge tb_clk);
    chk("rstbusy_busRen", busRen, 0);
    chk("rstbusy_stall", stall, 0);
    chk("rstbusy_memload", memload, 0);
    step();
    busAck = 1'b1; busRData = 32'h77777777;
    @(negedge tb_clk);
    chk("rstbusy_memValid0", memValid, 0);
    step();
    busAck = 1'b0;
    @(negedge tb_clk);
    chk("rstbusy_memValid1", memValid, 0);
    chk("rstbusy_memload1", memload, 0);
    step();
`ifdef LSU_MISALIGN_TRAP_EN
    memStart = 1'b1; cuOP = CU_LW; aluOut = 32'h4001; busRData = 32'h55667788;
    sb.push_back('{32'h0, 1'b1});
    @(negedge tb_clk);
    chk("mis_stall_start", stall, 1);
    step();
    memStart = 1'b0;
    @(negedge tb_clk);
    chk("mis_busRen", busRen, 0);
    chk("mis_memValid", memValid, 1);
    chk("mis_stall_done", stall, 0);
    step();
    @(negedge tb_clk);
    chk("mis_misalign_clear", misalign, 0);
    chk("mis_memValid_clear", memValid, 0);
    step();
`else
    run('{CU_LW, 32'h4001, 32'h0, 32'h55667788, 0, 32'h4000, 4'b1111, 32'h0, 1'b1, 32'h55667788});
    run('{CU_LH, 32'h0003, 32'h0, 32'hAABBCCDD, 1, 32'h0000, 4'b1100, 32'h0, 1'b1, 32'h0000AABB});
`endif
    chk("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the ALU and the write-back select. It takes the effective address from `aluOut` and the store operand, runs a request/acknowledge transaction on the data bus, and stalls the core while the transaction is outstanding. On loads it returns `memload` with the addressed byte or halfword shifted down to bit 0. The write-back select does the sign/zero extension.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Only 32 is supported.

Ports:
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `nRST`, in, 1: reset. Synchronous and active-high: 1 = reset, sampled on the `clk` rising edge. The port keeps the codebase's reset name.
- `memStart`, in, 1: request strobe from control. Sampled only in IDLE.
- `cuOP`, in, 6: control-unit opcode. Only CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH and CU_SW start a transaction.
- `aluOut`, in, 32: effective address.
- `storeData`, in, 32: rs2 value for stores.
- `busAddr`, out, 32: word-aligned bus address.
- `busWData`, out, 32: lane-replicated store data.
- `busByteEn`, out, 4: byte-lane enables.
- `busRen`, out, 1: read request.
- `busWen`, out, 1: write request.
- `busAck`, in, 1: bus completion. For reads, `busRData` is valid in the same cycle.
- `busRData`, in, 32: read data.
- `memload`, out, 32: lane-aligned load data to write-back.
- `memValid`, out, 1: one-cycle completion pulse.
- `stall`, out, 1: freezes PC and upstream registers.
- `misalign`, out, 1: misaligned-access flag, valid while `memValid` is high.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY: when `memStart` is high and `cuOP` is a memory op.
  - Register `cuOP`, `aluOut` and `storeData`.
  - Non-memory ops leave the FSM in IDLE.
- BUSY:
  - Drive `busRen` for loads or `busWen` for stores. Never both.
  - Hold all bus outputs stable until `busAck` is sampled high.
  - On ack: capture the aligned read data into `memload`, then go to DONE.
- DONE: `memValid` = 1 for exactly one cycle, then return to IDLE.
- `busAddr` = {addr[31:2], 2'b00}.
- Byte enables by size:
  - Byte: 4'b0001 << addr[1:0].
  - Halfword: 4'b0011 << {addr[1], 1'b0}.
  - Word: 4'b1111.
- Store data:
  - SB: {4{sd[7:0]}}.
  - SH: {2{sd[15:0]}}.
  - SW: sd.
- Load alignment:
  - Byte: `memload` = busRData >> (8 × addr[1:0]).
  - Halfword: `memload` = busRData >> (16 × addr[1]).
  - Word: unshifted.
  - Upper bits are whatever the shift leaves. Write-back masks or extends them.
- Stores capture nothing. `memload` keeps its previous value.
- `stall` = (IDLE && `memStart` && memory op) || BUSY. `stall` is low in DONE.
- Ignored inputs:
  - `memStart` while BUSY or DONE.
  - `busAck` while IDLE or DONE.
- Reset mid-transaction (`nRST` high in BUSY):
  - Next cycle: IDLE, with `busRen` and `busWen` = 0.
  - A late `busAck` is ignored.
- Reset values: state IDLE; all outputs 0, including `memload` = 32'h0.

## Timing
- Cycle 0: `memStart` accepted in IDLE; `stall` = 1 combinationally.
- Cycle 1: bus request visible (outputs are registered).
- Cycle 1+N: `busAck` sampled, where N ≥ 0 is the number of wait cycles.
- Cycle 2+N: `memValid` = 1, `stall` = 0.
- Minimum latency is 2 cycles from start to `memValid`.
- Back-to-back operations: the next `memStart` can be accepted on the cycle after DONE.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned cases: LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] ≠ 0.
  - These skip BUSY and go IDLE → DONE directly.
  - No bus request is issued.
  - `misalign` = 1 and `memload` = 0 alongside `memValid`.
- Undefined:
  - Offending low address bits are ignored: halfword accesses use addr[1] only; word accesses use lane 0.
  - `misalign` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the 6-bit `cuOP` enum (CU_LB … CU_SW);
  - the `lsu_state_t` enum;
  - the size-decode function: byte, half or word, signed flag, load/store.
- One combinational sub-module, `lsu_lane_align`. It computes `busByteEn`, `busWData` and the aligned read data from the opcode, address[1:0], store data and read data.
- The FSM, registers and stall logic live in the top module.

## Test plan
- Reset: hold `nRST` = 1 for 2 cycles → all outputs 0, state IDLE; `busAck` pulses are ignored.
- LB, zero wait: addr 0x1003, `busRData` 0xAABBCCDD, ack in cycle 1 →
  - `busAddr` 0x1000, `busByteEn` 4'b1000;
  - cycle 2: `memValid` = 1, `memload`[7:0] = 0xAA.
- SH, 3 wait cycles: addr 0x2002, `storeData` 0x12345678 →
  - `busWData` 0x56785678, `busByteEn` 4'b1100;
  - `stall` high cycles 0–4; `memValid` in cycle 5.
- LW, then `memStart` asserted during BUSY → second start ignored; exactly one `busRen` transaction; `memload` = `busRData`.
- Reset in BUSY: LW at 0x3000, `nRST` pulsed in cycle 2 → `busRen` = 0 in cycle 3; ack in cycle 4 gives no `memValid`.
- Misaligned LW at 0x4001:
  - With `LSU_MISALIGN_TRAP_EN`: no `busRen`; cycle 1 `memValid` = 1, `misalign` = 1, `memload` = 0.
  - Without it: the bus reads 0x4000 and `misalign` = 0.
